// File: rtl/ibuf_pkg.sv
// Shared definitions for the instruction prefetch queue: ring geometry,
// pointer widths and the fetch controller state encoding.
package ibuf_pkg;

  localparam int IBUF_WORDS = 16;
  localparam int IBUF_BYTES = 32;
  localparam int WR_PTR_W   = 5;
  localparam int RD_PTR_W   = 6;
  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } ibuf_state_e;

endpackage

// File: rtl/ibuf_if.sv
// Word-fetch handshake between the prefetch controller (master) and the
// bus interface unit (slave).
interface ibuf_if;
  import ibuf_pkg::*;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    output fetch_data
  );

endinterface

// File: rtl/ibuf_ctrl.sv
// Prefetch-queue controller: fetches words from the BIU into the 16-word
// instruction ring and presents the decoder's valid byte window.
module ibuf_ctrl
  import ibuf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  ibuf_if.master            bus,
  output logic              ram_we,
  output logic [3:0]        ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [2:0]        ram_raddr,
  output logic [1:0]        byte_sel,
  output logic [2:0]        win_bytes,
  output logic [5:0]        avail,
  input  logic [2:0]        consume
);

  ibuf_state_e         state;
  logic                started;
  logic                fetch_req_q;
  logic [ADDR_W-1:0]   fetch_addr_q;
  logic [ADDR_W-1:0]   new_addr;
  logic [WR_PTR_W-1:0] wr_ptr;
  logic [WR_PTR_W-1:0] vis_ptr;
  logic                vis_pend;
  logic [RD_PTR_W-1:0] rd_ptr;
  logic [RD_PTR_W-1:0] rd_ptr_next;
  logic [5:0]          fill;
  logic [2:0]          room;
  logic [2:0]          take;
  logic [WR_PTR_W-1:0] words_used;
  logic [WR_PTR_W-1:0] words_after;
  logic                full;
  logic                stay;

  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_addr = fetch_addr_q;

  // Only committed words count as available; a negative difference means the
  // skipped low byte after an odd flush is not yet backed by data.
  always_comb begin
    fill        = {vis_ptr, 1'b0} - rd_ptr;
    avail       = (fill > 6'(IBUF_BYTES)) ? 6'd0 : fill;
    room        = 3'd4 - {1'b0, rd_ptr[1:0]};
    win_bytes   = (avail < {3'b000, room}) ? avail[2:0] : room;
    byte_sel    = rd_ptr[1:0];
    take        = (consume > win_bytes) ? win_bytes : consume;
    if (rst)
      rd_ptr_next = '0;
    else if (flush)
      rd_ptr_next = {5'b0, flush_addr[0]};
    else
      rd_ptr_next = rd_ptr + {3'b000, take};
    ram_raddr   = rd_ptr_next[4:2];
    words_used  = wr_ptr - rd_ptr[5:1];
    full        = (words_used == 5'(IBUF_WORDS));
    words_after = wr_ptr + 5'd1 - rd_ptr_next[5:1];
    stay        = (words_after != 5'(IBUF_WORDS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      started      <= 1'b0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= '0;
      new_addr     <= '0;
      wr_ptr       <= '0;
      vis_ptr      <= '0;
      vis_pend     <= 1'b0;
      rd_ptr       <= '0;
      ram_we       <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      ram_we <= 1'b0;
      if (flush) begin
        started  <= 1'b1;
        wr_ptr   <= '0;
        vis_ptr  <= '0;
        vis_pend <= 1'b0;
        if (bus.fetch_ack) begin
          state        <= IDLE;
          fetch_req_q  <= 1'b0;
          fetch_addr_q <= {flush_addr[ADDR_W-1:1], 1'b0};
        end else if (state == IDLE) begin
          state        <= FETCH;
          fetch_req_q  <= 1'b1;
          fetch_addr_q <= {flush_addr[ADDR_W-1:1], 1'b0};
        end else begin
          // The BIU still owns the old request, so the new address waits.
          state    <= DISCARD;
          new_addr <= {flush_addr[ADDR_W-1:1], 1'b0};
        end
      end else begin
        // A word becomes visible one edge after the RAM has stored it.
        vis_pend <= ram_we;
        vis_ptr  <= vis_ptr + {4'b0, vis_pend};
        case (state)
          IDLE: begin
            if (started && !full) begin
              state       <= FETCH;
              fetch_req_q <= 1'b1;
            end
          end
          FETCH: begin
            if (bus.fetch_ack) begin
              ram_we       <= 1'b1;
              ram_waddr    <= wr_ptr[3:0];
              ram_wdata    <= bus.fetch_data;
              wr_ptr       <= wr_ptr + 5'd1;
              fetch_addr_q <= fetch_addr_q + 20'd2;
              if (!stay) begin
                state       <= IDLE;
                fetch_req_q <= 1'b0;
              end
            end
          end
          DISCARD: begin
            if (bus.fetch_ack) begin
              state        <= IDLE;
              fetch_req_q  <= 1'b0;
              fetch_addr_q <= new_addr;
            end
          end
          default: begin
            state       <= IDLE;
            fetch_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  consume_within_window: assert property (
    @(posedge clk) disable iff (rst || flush) consume <= win_bytes
  );

endmodule

// File: tb/tb_ibuf_ctrl.sv
// Self-checking bench for ibuf_ctrl: a byte-stream model of the prefetch
// queue plus a behavioural buffer RAM, driven by directed and random traffic.
module tb_ibuf_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [19:0] flush_addr;
  logic        ram_we;
  logic [3:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic [2:0]  ram_raddr;
  logic [1:0]  byte_sel;
  logic [2:0]  win_bytes;
  logic [5:0]  avail;
  logic [2:0]  consume;

  ibuf_if bus();

  ibuf_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_addr (flush_addr),
    .bus        (bus),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .byte_sel   (byte_sel),
    .win_bytes  (win_bytes),
    .avail      (avail),
    .consume    (consume)
  );

  always #5 clk = ~clk;

  logic [15:0] ram_mem [16];
  logic [31:0] ram_q;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    ram_q <= {ram_mem[{ram_raddr, 1'b1}], ram_mem[{ram_raddr, 1'b0}]};
  end

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference state: stream position in bytes from the even flush base,
  // word counts since the flush, and the request/discard bookkeeping.
  int          m_started, m_req, m_stale, m_we;
  logic [19:0] m_next_addr, m_stale_addr, m_base;
  int          m_wr, m_vis, m_d0, m_d1, m_rd, m_waddr;
  logic [15:0] m_wdata;

  function automatic logic [15:0] word_at(input logic [19:0] a);
    logic [15:0] w;
    w = 16'h1080 + a[16:1];
    return w ^ {a[19:17], 13'b0};
  endfunction

  function automatic logic [7:0] stream_byte(input int k);
    logic [19:0] ad;
    logic [15:0] w;
    ad = m_base + 20'(k);
    w  = word_at({ad[19:1], 1'b0});
    return ad[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic int model_avail();
    int a;
    a = 2 * m_vis - m_rd;
    if (a < 0) a = 0;
    if (a > 32) a = 32;
    return a;
  endfunction

  function automatic int model_win();
    int a, r;
    a = model_avail();
    r = 4 - (m_rd % 4);
    return (a < r) ? a : r;
  endfunction

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cycle);
    end
  endfunction

  task automatic model_reset();
    m_started = 0; m_req = 0; m_stale = 0; m_we = 0;
    m_next_addr = '0; m_stale_addr = '0; m_base = '0;
    m_wr = 0; m_vis = 0; m_d0 = 0; m_d1 = 0; m_rd = 0; m_waddr = 0; m_wdata = '0;
  endtask

  task automatic model_edge(input logic r, input logic f, input logic [19:0] fa,
                            input logic ack, input logic [2:0] cons);
    int used_now, c, w;
    if (r) begin
      model_reset();
      return;
    end
    used_now = m_wr - (m_rd >> 1);
    w = model_win();
    c = (int'(cons) > w) ? w : int'(cons);
    if (f) begin
      if (m_req != 0 && !ack) begin
        if (m_stale == 0) m_stale_addr = m_next_addr;
        m_stale = 1;
      end else begin
        m_stale = 0;
      end
      m_req = ack ? 0 : 1;
      m_started = 1;
      m_base = {fa[19:1], 1'b0};
      m_next_addr = {fa[19:1], 1'b0};
      m_wr = 0; m_vis = 0; m_d0 = 0; m_d1 = 0; m_we = 0;
      m_rd = int'(fa[0]);
    end else begin
      m_vis += m_d1;
      m_d1 = m_d0;
      m_d0 = 0;
      m_we = 0;
      m_rd += c;
      if (m_req != 0 && ack && m_stale != 0) begin
        m_stale = 0;
        m_req = 0;
      end else if (m_req != 0 && ack) begin
        cmp("ring_room_at_ack", (used_now < 16) ? 1 : 0, 1);
        m_we = 1;
        m_waddr = m_wr % 16;
        m_wdata = word_at(m_next_addr);
        m_wr++;
        m_next_addr += 20'd2;
        m_d0 = 1;
        m_req = ((m_wr - (m_rd >> 1)) < 16) ? 1 : 0;
      end else if (m_req == 0) begin
        m_req = (m_started != 0 && used_now < 16) ? 1 : 0;
      end
    end
  endtask

  task automatic checkOutput();
    int a, w, sel;
    a = model_avail();
    w = model_win();
    sel = m_rd % 4;
    cmp("fetch_req", 32'(bus.fetch_req), 32'(m_req));
    if (m_req != 0)
      cmp("fetch_addr", 32'(bus.fetch_addr), 32'((m_stale != 0) ? m_stale_addr : m_next_addr));
    cmp("ram_we", 32'(ram_we), 32'(m_we));
    if (m_we != 0) begin
      cmp("ram_waddr", 32'(ram_waddr), 32'(m_waddr));
      cmp("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    end
    cmp("avail", 32'(avail), 32'(a));
    cmp("win_bytes", 32'(win_bytes), 32'(w));
    cmp("byte_sel", 32'(byte_sel), 32'(sel));
    for (int i = 0; i < w; i++)
      cmp("window_byte", 32'(ram_q[8*(sel+i) +: 8]), 32'(stream_byte(m_rd + i)));
  endtask

  // Called at a falling edge: drives one cycle of inputs, advances the model
  // across the rising edge, then checks at the next falling edge.
  task automatic applyStimulus(input logic r, input logic f, input logic [19:0] fa,
                               input logic ack, input logic [2:0] cons);
    rst = r;
    flush = f;
    flush_addr = fa;
    bus.fetch_ack = ack;
    bus.fetch_data = word_at(bus.fetch_addr);
    consume = cons;
    @(posedge clk);
    model_edge(r, f, fa, ack, cons);
    cycle++;
    @(negedge clk);
    checkOutput();
  endtask

  int          nwr;
  logic [3:0]  last_waddr;
  logic [15:0] last_wdata;

  initial begin
    logic r, f, ack;
    logic [19:0] fa;
    rst = 1'b1; flush = 1'b0; flush_addr = '0; consume = '0;
    bus.fetch_ack = 1'b0; bus.fetch_data = '0;
    model_reset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("reset_fetch_req", 32'(bus.fetch_req), 0);
    cmp("reset_fetch_addr", 32'(bus.fetch_addr), 0);
    cmp("reset_avail", 32'(avail), 0);
    cmp("reset_win", 32'(win_bytes), 0);
    cmp("reset_raddr", 32'(ram_raddr), 0);

    // No fetching before the first flush.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("idle_before_flush", 32'(bus.fetch_req), 0);

    // Fill the whole ring from 00100h with an always-ready BIU.
    applyStimulus(1'b0, 1'b1, 20'h00100, 1'b0, 3'd0);
    cmp("fill_first_req", 32'(bus.fetch_req), 1);
    cmp("fill_first_addr", 32'(bus.fetch_addr), 32'h00100);
    nwr = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, 20'h0, m_req != 0, 3'd0);
      if (ram_we) begin
        nwr++;
        last_waddr = ram_waddr;
        last_wdata = ram_wdata;
      end
    end
    cmp("fill_write_count", 32'(nwr), 16);
    cmp("fill_last_waddr", 32'(last_waddr), 15);
    cmp("fill_last_wdata", 32'(last_wdata), 32'h110F);
    cmp("fill_avail", 32'(avail), 32);
    cmp("fill_req_low", 32'(bus.fetch_req), 0);

    // Drain four bytes per cycle and let the ring refill across the wrap.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 20'h0, m_req != 0, 3'd4);
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0, 20'h0, m_req != 0, 3'd0);
    cmp("refill_avail", 32'(avail), 32);
    cmp("refill_fetch_addr", 32'(bus.fetch_addr), 32'h00140);
    cmp("refill_req_low", 32'(bus.fetch_req), 0);

    // Odd flush target skips the low byte of the first word.
    applyStimulus(1'b0, 1'b1, 20'h00103, 1'b0, 3'd0);
    cmp("odd_fetch_addr", 32'(bus.fetch_addr), 32'h00102);
    applyStimulus(1'b0, 1'b0, 20'h0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("odd_byte_sel", 32'(byte_sel), 1);
    cmp("odd_avail", 32'(avail), 1);
    cmp("odd_win", 32'(win_bytes), 1);

    // Reset while a request is outstanding.
    applyStimulus(1'b1, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("midreset_req", 32'(bus.fetch_req), 0);
    cmp("midreset_addr", 32'(bus.fetch_addr), 0);
    cmp("midreset_we", 32'(ram_we), 0);
    cmp("midreset_waddr", 32'(ram_waddr), 0);
    cmp("midreset_wdata", 32'(ram_wdata), 0);
    cmp("midreset_avail", 32'(avail), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("midreset_no_fetch", 32'(bus.fetch_req), 0);

    // Flush while a request waits three cycles for its ack.
    applyStimulus(1'b0, 1'b1, 20'h00500, 1'b0, 3'd0);
    cmp("disc_req_rise", 32'(bus.fetch_req), 1);
    cmp("disc_old_addr", 32'(bus.fetch_addr), 32'h00500);
    applyStimulus(1'b0, 1'b1, 20'h02345, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("disc_hold_addr", 32'(bus.fetch_addr), 32'h00500);
    applyStimulus(1'b0, 1'b0, 20'h0, 1'b1, 3'd0);
    cmp("disc_no_write", 32'(ram_we), 0);
    cmp("disc_req_gap", 32'(bus.fetch_req), 0);
    applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("disc_new_req", 32'(bus.fetch_req), 1);
    cmp("disc_new_addr", 32'(bus.fetch_addr), 32'h02344);

    // Flush coinciding with an ack.
    applyStimulus(1'b0, 1'b1, 20'h07777, 1'b1, 3'd0);
    cmp("same_no_write", 32'(ram_we), 0);
    cmp("same_req_low", 32'(bus.fetch_req), 0);
    applyStimulus(1'b0, 1'b0, 20'h0, 1'b0, 3'd0);
    cmp("same_new_addr", 32'(bus.fetch_addr), 32'h07776);

    // Random traffic: jumps, stalled BIU, partial consumes, rare resets.
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 599) == 0);
      f   = !r && ($urandom_range(0, 29) == 0);
      fa  = 20'($urandom);
      ack = !r && (m_req != 0) && ($urandom_range(0, 3) != 0);
      applyStimulus(r, f, fa, ack, 3'($urandom_range(0, model_win())));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
